// File: rtl/sss_pkg.sv
// Shared SSS constants, LFSR parameters and FSM encoding for the SSS generator and detector.
package sss_pkg;

    localparam logic [8:0] N_ID_1_MAX = 9'd335;
    localparam logic [1:0] N_ID_2_MAX = 2'd2;
    localparam logic [6:0] SSS_LEN    = 7'd127;
    localparam logic [6:0] LFSR_INIT  = 7'b0000001;
    localparam int         X0_TAP     = 4;
    localparam int         X1_TAP     = 1;

    typedef logic [1:0] sss_state_t;
    localparam sss_state_t ST_IDLE   = 2'd0;
    localparam sss_state_t ST_ALIGN  = 2'd1;
    localparam sss_state_t ST_OUTPUT = 2'd2;

    function automatic logic id_valid(input logic [8:0] n1, input logic [1:0] n2);
        return (n1 <= N_ID_1_MAX) && (n2 <= N_ID_2_MAX);
    endfunction

endpackage

// File: rtl/sss_lfsr.sv
// 7-bit Fibonacci LFSR: state[k] holds x(i+k); x(i+7) = x(i+TAP) xor x(i).
module sss_lfsr
    import sss_pkg::*;
#(
    parameter int TAP = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic       step_i,
    output logic [6:0] state_o
);

    logic [6:0] state_r;

    // shift register: load has priority over step
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= 7'd0;
        end else if (load_i) begin
            state_r <= LFSR_INIT;
        end else if (step_i) begin
            state_r <= {state_r[TAP] ^ state_r[0], state_r[6:1]};
        end else begin
            state_r <= state_r;
        end
    end

    assign state_o = state_r;

endmodule

// File: rtl/sss_generator.sv
// SSS BPSK sequence generator with AXI-stream output.
// Optional IQ output port enabled by defining SSS_GENERATOR_IQ_OUT_EN.
module sss_generator
    import sss_pkg::*;
#(
    parameter int OUT_DW    = 32,
    parameter int AMPLITUDE = 8191
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [8:0]        N_id_1_i,
    input  logic [1:0]        N_id_2_i,
    input  logic              start_i,
    output logic              ready_o,
    output logic              error_o,
    output logic              m_axis_out_tdata,
    output logic              m_axis_out_tvalid,
    input  logic              m_axis_out_tready,
    output logic              m_axis_out_tlast,
`ifdef SSS_GENERATOR_IQ_OUT_EN
    output logic [OUT_DW-1:0] m_axis_iq_tdata,
`endif
    output logic [9:0]        N_id_o
);

    sss_state_t  state_r;
    logic [5:0]  m0_r;
    logic [6:0]  m1_r;
    logic [7:0]  cnt_r;
    logic [6:0]  n_r;
    logic        tvalid_r, tlast_r, tdata_r, error_r;
    logic [9:0]  n_id_r;

    logic [5:0]  m0_s;
    logic [6:0]  m1_s;
    logic [8:0]  sub_s;
    logic [6:0]  mmax_s;
    logic [9:0]  nid_s;
    logic        accept_s, load_s, hs_s, align_done_s;
    logic        x0_step_s, x1_step_s, sym_first_s, sym_next_s;
    logic [6:0]  x0_s, x1_s;

    // m0/m1 decode: floor(N_id_1/112) resolved by range compare
    always_comb begin
        m0_s  = 6'd0;
        sub_s = 9'd0;
        if (N_id_1_i >= 9'd224) begin
            m0_s  = 6'd30;
            sub_s = 9'd224;
        end else if (N_id_1_i >= 9'd112) begin
            m0_s  = 6'd15;
            sub_s = 9'd112;
        end else begin
            m0_s  = 6'd0;
            sub_s = 9'd0;
        end
        case (N_id_2_i)
            2'd1:    m0_s = m0_s + 6'd5;
            2'd2:    m0_s = m0_s + 6'd10;
            default: m0_s = m0_s;
        endcase
        m1_s  = 7'(N_id_1_i - sub_s);
        nid_s = 10'(N_id_1_i) * 10'd3 + {8'd0, N_id_2_i};
    end

    assign accept_s     = start_i && (state_r == ST_IDLE);
    assign load_s       = accept_s && id_valid(N_id_1_i, N_id_2_i);
    assign hs_s         = tvalid_r && m_axis_out_tready;
    assign mmax_s       = (m1_r > {1'b0, m0_r}) ? m1_r : {1'b0, m0_r};
    // one idle ALIGN cycle after the last step lets the first symbol register from settled LFSRs
    assign align_done_s = (cnt_r == ({1'b0, mmax_s} + 8'd1));
    assign x0_step_s    = ((state_r == ST_ALIGN) && (cnt_r < {2'b00, m0_r})) || hs_s;
    assign x1_step_s    = ((state_r == ST_ALIGN) && (cnt_r < {1'b0, m1_r})) || hs_s;
    assign sym_first_s  = ~(x0_s[0] ^ x1_s[0]);
    assign sym_next_s   = ~(x0_s[1] ^ x1_s[1]);

    sss_lfsr #(.TAP(X0_TAP)) u_x0 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (load_s),
        .step_i  (x0_step_s),
        .state_o (x0_s)
    );

    sss_lfsr #(.TAP(X1_TAP)) u_x1 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (load_s),
        .step_i  (x1_step_s),
        .state_o (x1_s)
    );

    // control FSM and registered stream outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= ST_IDLE;
            m0_r     <= 6'd0;
            m1_r     <= 7'd0;
            cnt_r    <= 8'd0;
            n_r      <= 7'd0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tdata_r  <= 1'b0;
            error_r  <= 1'b0;
            n_id_r   <= 10'd0;
        end else begin
            error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        m0_r    <= m0_s;
                        m1_r    <= m1_s;
                        n_id_r  <= nid_s;
                        cnt_r   <= 8'd0;
                        n_r     <= 7'd0;
                        state_r <= ST_ALIGN;
                    end else if (accept_s) begin
                        error_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ALIGN: begin
                    if (align_done_s) begin
                        state_r  <= ST_OUTPUT;
                        tvalid_r <= 1'b1;
                        tdata_r  <= sym_first_s;
                        tlast_r  <= 1'b0;
                        n_r      <= 7'd0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_OUTPUT: begin
                    if (hs_s && tlast_r) begin
                        state_r  <= ST_IDLE;
                        tvalid_r <= 1'b0;
                        tlast_r  <= 1'b0;
                        tdata_r  <= 1'b0;
                    end else if (hs_s) begin
                        n_r     <= n_r + 7'd1;
                        tdata_r <= sym_next_s;
                        tlast_r <= (n_r == (SSS_LEN - 7'd2));
                    end else begin
                        state_r <= ST_OUTPUT;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    tvalid_r <= 1'b0;
                    tlast_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SSS_GENERATOR_IQ_OUT_EN
    localparam int HW = OUT_DW / 2;
    localparam logic [HW-1:0] AMP_P = HW'(AMPLITUDE);
    localparam logic [HW-1:0] AMP_N = HW'(-AMPLITUDE);

    logic [OUT_DW-1:0] iq_r;

    function automatic logic [OUT_DW-1:0] iq_word(input logic b);
        return {{(OUT_DW - HW){1'b0}}, (b ? AMP_P : AMP_N)};
    endfunction

    // IQ word follows the symbol register on identical load conditions
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            iq_r <= '0;
        end else if ((state_r == ST_ALIGN) && align_done_s) begin
            iq_r <= iq_word(sym_first_s);
        end else if (hs_s && tlast_r) begin
            iq_r <= '0;
        end else if (hs_s) begin
            iq_r <= iq_word(sym_next_s);
        end else begin
            iq_r <= iq_r;
        end
    end

    assign m_axis_iq_tdata = iq_r;
`endif

    assign ready_o           = (state_r == ST_IDLE);
    assign error_o           = error_r;
    assign m_axis_out_tdata  = tdata_r;
    assign m_axis_out_tvalid = tvalid_r;
    assign m_axis_out_tlast  = tlast_r;
    assign N_id_o            = n_id_r;

endmodule

// File: tb/tb_sss_generator.sv
// Directed self-checking bench for sss_generator against a recurrence-based golden sequence.
module tb_sss_generator;

    logic       clk = 1'b0;
    logic       reset_i, start_i, tready;
    logic [8:0] n1_in;
    logic [1:0] n2_in;
    logic       ready_o, error_o, tdata, tvalid, tlast;
    logic [9:0] N_id_o;

    int checks = 0;
    int failures = 0;
    logic x0m [127];
    logic x1m [127];

    always #5 clk = ~clk;

    sss_generator dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .N_id_1_i          (n1_in),
        .N_id_2_i          (n2_in),
        .start_i           (start_i),
        .ready_o           (ready_o),
        .error_o           (error_o),
        .m_axis_out_tdata  (tdata),
        .m_axis_out_tvalid (tvalid),
        .m_axis_out_tready (tready),
        .m_axis_out_tlast  (tlast),
        .N_id_o            (N_id_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input int n, input int m0, input int m1);
        return ~(x0m[(n + m0) % 127] ^ x1m[(n + m1) % 127]);
    endfunction

    // accept one request, measure latency, then consume the stream with optional stall/poke/reset
    task automatic run_stream(input int n1, input int n2, input int stall_at, input int poke_at,
                              input int rst_at, output int lat, output int hs, output int bad,
                              output logic first);
        int m0, m1, n, guard, stalls;
        m0 = 15 * (n1 / 112) + 5 * n2;
        m1 = n1 % 112;
        n1_in = 9'(n1);
        n2_in = 2'(n2);
        start_i = 1'b1;
        tready = 1'b1;
        tick();
        start_i = 1'b0;
        lat = 0;
        while (!tvalid && lat < 300) begin
            tick();
            lat++;
        end
        first = tdata;
        hs = 0; bad = 0; n = 0; guard = 0; stalls = 0;
        while (n < 127 && guard < 1000) begin
            guard++;
            if (n == rst_at) begin
                reset_i = 1'b1;
                tick();
                reset_i = 1'b0;
                return;
            end
            if (n == poke_at) begin
                start_i = 1'b1;
                n1_in = 9'd5;
                n2_in = 2'd0;
            end else begin
                start_i = 1'b0;
            end
            tready = 1'b1;
            if (n == stall_at && stalls < 10) begin
                tready = 1'b0;
                stalls++;
                if (tdata !== exp_bit(n, m0, m1) || tvalid !== 1'b1 || tlast !== 1'b0) bad++;
            end else if (tvalid) begin
                if (tdata !== exp_bit(n, m0, m1)) bad++;
                if (tlast !== (n == 126)) bad++;
                hs++;
                n++;
            end else begin
                bad++;
            end
            tick();
        end
        start_i = 1'b0;
        tready = 1'b1;
    endtask

    initial begin
        int lat, hs, bad;
        logic first;

        x0m[0] = 1'b1;
        x1m[0] = 1'b1;
        for (int i = 1; i < 7; i++) begin
            x0m[i] = 1'b0;
            x1m[i] = 1'b0;
        end
        for (int i = 0; i < 120; i++) begin
            x0m[i + 7] = x0m[i + 4] ^ x0m[i];
            x1m[i + 7] = x1m[i + 1] ^ x1m[i];
        end

        reset_i = 1'b1; start_i = 1'b0; tready = 1'b1; n1_in = 9'd0; n2_in = 2'd0;
        tick(); tick(); tick();
        reset_i = 1'b0;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_error", 32'(error_o), 32'd0);
        check("rst_nid", 32'(N_id_o), 32'd0);

        // N_id_1=0, N_id_2=0
        run_stream(0, 0, -1, -1, -1, lat, hs, bad, first);
        check("id0_latency", 32'(lat), 32'd2);
        check("id0_first_bit", 32'(first), 32'd1);
        check("id0_seq_errors", 32'(bad), 32'd0);
        check("id0_handshakes", 32'(hs), 32'd127);
        check("id0_tvalid_after", 32'(tvalid), 32'd0);
        check("id0_ready_after", 32'(ready_o), 32'd1);
        check("id0_nid", 32'(N_id_o), 32'd0);

        // N_id_1=335, N_id_2=2: m0=40, m1=111
        run_stream(335, 2, -1, -1, -1, lat, hs, bad, first);
        check("max_latency", 32'(lat), 32'd113);
        check("max_seq_errors", 32'(bad), 32'd0);
        check("max_handshakes", 32'(hs), 32'd127);
        check("max_nid", 32'(N_id_o), 32'd1007);

        // out-of-range requests
        n1_in = 9'd336; n2_in = 2'd0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("err336_pulse", 32'(error_o), 32'd1);
        check("err336_ready", 32'(ready_o), 32'd1);
        check("err336_nid", 32'(N_id_o), 32'd1007);
        tick();
        check("err336_pulse_end", 32'(error_o), 32'd0);
        n1_in = 9'd0; n2_in = 2'd3; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("err_n2_pulse", 32'(error_o), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("err_n2_pulse_end", 32'(error_o), 32'd0);
        check("err_n2_tvalid", 32'(tvalid), 32'd0);
        check("err_n2_ready", 32'(ready_o), 32'd1);
        check("err_n2_nid", 32'(N_id_o), 32'd1007);

        // N_id_1=100, N_id_2=1 with a 10-cycle stall at n=50: m0=5, m1=100
        run_stream(100, 1, 50, -1, -1, lat, hs, bad, first);
        check("stall_latency", 32'(lat), 32'd102);
        check("stall_seq_errors", 32'(bad), 32'd0);
        check("stall_handshakes", 32'(hs), 32'd127);
        check("stall_nid", 32'(N_id_o), 32'd301);

        // start poked at n=20 with N_id_1=7, N_id_2=2: m0=10, m1=7
        run_stream(7, 2, -1, 20, -1, lat, hs, bad, first);
        check("poke_latency", 32'(lat), 32'd12);
        check("poke_seq_errors", 32'(bad), 32'd0);
        check("poke_handshakes", 32'(hs), 32'd127);
        check("poke_nid", 32'(N_id_o), 32'd23);
        tick();
        check("poke_no_restart", 32'(tvalid), 32'd0);
        check("poke_ready", 32'(ready_o), 32'd1);

        // reset at n=60 of N_id_1=200, then N_id_1=5: m0=0, m1=5
        run_stream(200, 0, -1, -1, 60, lat, hs, bad, first);
        check("rstmid_handshakes", 32'(hs), 32'd60);
        check("rstmid_tvalid", 32'(tvalid), 32'd0);
        check("rstmid_tlast", 32'(tlast), 32'd0);
        check("rstmid_ready", 32'(ready_o), 32'd1);
        run_stream(5, 0, -1, -1, -1, lat, hs, bad, first);
        check("after_rst_latency", 32'(lat), 32'd7);
        check("after_rst_seq_errors", 32'(bad), 32'd0);
        check("after_rst_handshakes", 32'(hs), 32'd127);
        check("after_rst_nid", 32'(N_id_o), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sss_generator.md
SSS_GENERATOR -- requirements
Module: sss_generator

Interface
REQ-001 SHALL have parameter OUT_DW, default 32, width of the complex IQ output (I in low half, Q in high half).
REQ-002 SHALL have parameter AMPLITUDE, default 8191, signed magnitude of the IQ real part for a +1 symbol.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port reset_i, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port N_id_1_i, input, 9, the cell-ID group, valid range 0..335.
REQ-006 SHALL have port N_id_2_i, input, 2, the PSS index, valid range 0..2.
REQ-007 SHALL have port start_i, input, 1, the request pulse; it is sampled only when ready_o=1.
REQ-008 SHALL have port ready_o, output, 1, high only in IDLE.
REQ-009 SHALL have port error_o, output, 1, a one-cycle pulse on an accepted start with an out-of-range ID.
REQ-010 SHALL have port m_axis_out_tdata, output, 1, the BPSK symbol bit: 1 means +1, 0 means -1 (SSS detector input convention).
REQ-011 SHALL have ports m_axis_out_tvalid (output, 1), m_axis_out_tready (input, 1) and m_axis_out_tlast (output, 1), the AXI-stream handshake.
REQ-012 SHALL have port N_id_o, output, 10, the registered value 3*N_id_1+N_id_2 of the last valid request.

Function
REQ-013 SHALL compute m0=15*floor(N_id_1/112)+5*N_id_2 and m1=N_id_1 mod 112, registered on the accepting edge.
REQ-014 SHALL use a 7-bit LFSR x0 with x0(i+7)=x0(i+4) xor x0(i) and a 7-bit LFSR x1 with x1(i+7)=x1(i+1) xor x1(i), each initialised to x(6:0)=0000001 on start acceptance.
REQ-015 SHALL run the state machine IDLE -> ALIGN -> OUTPUT -> IDLE: IDLE asserts ready_o; ALIGN advances x0 m0 steps and x1 m1 steps, each LFSR at one step per cycle in parallel; OUTPUT emits 127 symbols.
REQ-016 SHALL emit m_axis_out_tdata(n) = not(x0((n+m0) mod 127) xor x1((n+m1) mod 127)) for n=0..126.
REQ-017 SHALL raise m_axis_out_tvalid exactly max(m0,m1)+2 clock edges after the accepting edge.
REQ-018 SHALL advance both LFSRs by one step only on a cycle with tvalid and tready both high; while tready=0, tdata, tlast and tvalid SHALL remain stable.
REQ-019 SHALL assert m_axis_out_tlast with symbol n=126 only, and on that handshake return to IDLE with tvalid=0 on the next cycle.
REQ-020 SHALL ignore start_i while ready_o=0, with no effect on the stream in flight.
REQ-021 SHALL, on an accepted start with N_id_1>335 or N_id_2>2, pulse error_o for one cycle, stay in IDLE, leave N_id_o unchanged and produce no tvalid.
REQ-022 SHALL update N_id_o on the accepting edge of a valid request.

Reset
REQ-023 SHALL, while reset_i=1 at a clock edge, set state=IDLE, ready_o=1, tvalid=0, tlast=0, tdata=0, error_o=0, N_id_o=0 and all counters and LFSRs to 0.
REQ-024 SHALL treat reset mid-ALIGN or mid-OUTPUT as abandoning the sequence, with no tlast emitted; the next start SHALL restart from n=0.

Configuration
REQ-025 SHALL, when SSS_GENERATOR_IQ_OUT_EN is defined, add output port m_axis_iq_tdata (OUT_DW) carrying I=+AMPLITUDE or -AMPLITUDE per the symbol and Q=0, on the same handshake and timing as m_axis_out_tdata.
REQ-026 SHALL, when SSS_GENERATOR_IQ_OUT_EN is undefined, omit that port and its logic entirely.

Structure
REQ-027 SHALL take the constants N_ID_1_MAX=335, N_ID_2_MAX=2, SSS_LEN=127, the LFSR init value, the x0/x1 tap positions and the state enum from a shared package sss_pkg, which the SSS detector also uses.
REQ-028 SHALL contain one sub-module, sss_lfsr: a 7-bit Fibonacci LFSR with load, step enable and tap-select parameter, instantiated twice (x0, x1).

Verification
REQ-029 SHALL cover: N_id_1=0, N_id_2=0, tready=1 -> tvalid 2 edges after accept, 127 bits equal to the golden model, first bit 1, tlast on bit 126, N_id_o=0.
REQ-030 SHALL cover: N_id_1=335, N_id_2=2 -> m0=40, m1=111, tvalid 113 edges after accept, sequence matches the golden model, N_id_o=1007.
REQ-031 SHALL cover: N_id_1=336 or N_id_2=3 -> one-cycle error_o, tvalid stays 0, ready_o stays 1, N_id_o unchanged.
REQ-032 SHALL cover: N_id_1=100, N_id_2=1, tready low for 10 cycles at n=50 -> data stable throughout, the resumed stream has no lost or duplicated symbol, exactly 127 handshakes in total.
REQ-033 SHALL cover: start pulsed during OUTPUT at n=20 -> ignored, current sequence completes unchanged.
REQ-034 SHALL cover: reset_i high at n=60 -> next edge tvalid=0 and ready_o=1; a new start with N_id_1=5 gives the full correct sequence.
